// File: rtl/cp0_timer_unit.sv
// cp0_timer_unit
// Free-running CP0 Count with a programmable prescaler and NUM_CMP
// independent Compare channels. Each channel owns a sticky pending flag.
// The flags are OR-reduced into a registered timer interrupt (Cause.IP7).
// The unit shares the WB-stage CP0 write port and serves mfc0 reads for
// its own register addresses.
//
// Register map (addr/sel):
//   9/0          Count
//   11/i         Compare[i], i < NUM_CMP
//   22/0         Pending flags, write-1-to-clear
//   22/1..N      Reload period of channel sel-1 (CP0_TIMER_RELOAD_EN only)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   we, except_occur    write enable; an exception squashes the write
//   waddr, wsel, wdata  write address, select and data
//   raddr, rsel, rdata  combinational read of registered state
//   count_stop          freezes Count and the prescaler
//   timer_pend          per-channel pending flags (registered)
//   timer_int           registered OR of timer_pend
//
// Optional feature macro: CP0_TIMER_RELOAD_EN adds per-channel period
// registers that automatically advance Compare on every match.
module cp0_timer_unit #(
    parameter int NUM_CMP   = 4,
    parameter int CNT_W     = 32,
    parameter int COUNT_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               except_occur,
    input  logic [4:0]         waddr,
    input  logic [2:0]         wsel,
    input  logic [31:0]        wdata,
    input  logic [4:0]         raddr,
    input  logic [2:0]         rsel,
    output logic [31:0]        rdata,
    input  logic               count_stop,
    output logic [NUM_CMP-1:0] timer_pend,
    output logic               timer_int
);

    localparam int PC_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(COUNT_DIV - 1);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_PENDING = 5'd22;

    logic                 wr_s;
    logic                 count_wr_s;
    logic                 pend_wr_s;
    logic [NUM_CMP-1:0]   cmp_wr_s;
    logic [NUM_CMP-1:0]   match_s;
    logic [NUM_CMP-1:0]   clear_s;
    logic [CNT_W-1:0]     count_r;
    logic [PC_W-1:0]      pc_r;
    logic [CNT_W-1:0]     compare_r [NUM_CMP];
    logic [NUM_CMP-1:0]   pend_r;
    logic                 int_r;
`ifdef CP0_TIMER_RELOAD_EN
    logic [NUM_CMP-1:0]   period_wr_s;
    logic [CNT_W-1:0]     period_r [NUM_CMP];
`endif

    // Write decode, per-channel match detection and clear requests
    always_comb begin
        wr_s       = we & ~except_occur;
        count_wr_s = wr_s && (waddr == ADDR_COUNT) && (wsel == 3'd0);
        pend_wr_s  = wr_s && (waddr == ADDR_PENDING) && (wsel == 3'd0);
        cmp_wr_s   = '0;
        match_s    = '0;
        clear_s    = '0;
`ifdef CP0_TIMER_RELOAD_EN
        period_wr_s = '0;
`endif
        for (int i = 0; i < NUM_CMP; i++) begin
            cmp_wr_s[i] = wr_s && (waddr == ADDR_COMPARE) && (wsel == 3'(i));
            // Compare == 0 disables the channel.
            match_s[i]  = (compare_r[i] != '0) && (compare_r[i] == count_r);
            clear_s[i]  = cmp_wr_s[i] | (pend_wr_s & wdata[i]);
`ifdef CP0_TIMER_RELOAD_EN
            // Channel 7 of an 8-channel build has no reachable select.
            period_wr_s[i] = wr_s && (waddr == ADDR_PENDING) && ((i + 1) < 8)
                             && (wsel == 3'(i + 1));
`endif
        end
    end

    // Count and prescaler; a Count write restarts the prescale period
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            pc_r    <= '0;
        end else if (count_wr_s) begin
            count_r <= wdata[CNT_W-1:0];
            pc_r    <= '0;
        end else if (!count_stop) begin
            if (pc_r == PC_LAST) begin
                pc_r    <= '0;
                count_r <= count_r + CNT_W'(1);
            end else begin
                pc_r    <= pc_r + PC_W'(1);
            end
        end else begin
            count_r <= count_r;
            pc_r    <= pc_r;
        end
    end

    // Compare registers; software writes override an automatic reload
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CMP; i++) begin
            if (rst) begin
                compare_r[i] <= '0;
            end else if (cmp_wr_s[i]) begin
                compare_r[i] <= wdata[CNT_W-1:0];
`ifdef CP0_TIMER_RELOAD_EN
            end else if (match_s[i] && (period_r[i] != '0)) begin
                compare_r[i] <= compare_r[i] + period_r[i];
`endif
            end else begin
                compare_r[i] <= compare_r[i];
            end
        end
    end

`ifdef CP0_TIMER_RELOAD_EN
    // Reload period registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CMP; i++) begin
            if (rst) begin
                period_r[i] <= '0;
            end else if (period_wr_s[i]) begin
                period_r[i] <= wdata[CNT_W-1:0];
            end else begin
                period_r[i] <= period_r[i];
            end
        end
    end
`endif

    // Sticky pending flags (clear beats a same-cycle match) and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= '0;
            int_r  <= 1'b0;
        end else begin
            pend_r <= (pend_r | match_s) & ~clear_s;
            int_r  <= |pend_r;
        end
    end

    // Read mux over registered state; unmapped addresses read zero
    always_comb begin
        rdata = 32'd0;
        case (raddr)
            ADDR_COUNT: begin
                if (rsel == 3'd0) rdata = 32'(count_r);
                else              rdata = 32'd0;
            end
            ADDR_COMPARE: begin
                for (int i = 0; i < NUM_CMP; i++) begin
                    rdata = rdata | ((rsel == 3'(i)) ? 32'(compare_r[i]) : 32'd0);
                end
            end
            ADDR_PENDING: begin
                if (rsel == 3'd0) begin
                    rdata = 32'(pend_r);
                end else begin
                    rdata = 32'd0;
`ifdef CP0_TIMER_RELOAD_EN
                    for (int i = 0; i < NUM_CMP; i++) begin
                        rdata = rdata | ((((i + 1) < 8) && (rsel == 3'(i + 1)))
                                         ? 32'(period_r[i]) : 32'd0);
                    end
`endif
                end
            end
            default: rdata = 32'd0;
        endcase
    end

    assign timer_pend = pend_r;
    assign timer_int  = int_r;

endmodule
